// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem
// Purpose  : EX/MEM pipeline register. It captures execute-stage results and
//            resolves branches into a one-cycle taken pulse plus a registered
//            target. It also owns the data-memory request handshake, stalls
//            the upstream pipeline while a load/store waits on memory, and
//            turns flushes and memory timeouts into bubbles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_WAIT : mem_ready-low cycles tolerated in ACCESS before abandoning
//   CNT_W    : wait counter width, 2**CNT_W must exceed MAX_WAIT
// Optional feature
//   EX_MEM_PERF_EN : when defined, stall_cycles counts hold cycles (wraps at
//                    2**32); when undefined stall_cycles is tied to zero
// Ports
//   clock, reset        : pipeline clock, synchronous active-high reset
//   flush               : turn the next loaded instruction into a bubble
//   ex_*                : execute-stage results and control bits
//   mem_ready           : memory completes the access this cycle
//   mem_req             : memory access request
//   mem_valid           : slot holds a real instruction
//   alu_result, write_data, write_reg : registered datapath
//   mem_read, mem_write, reg_write, mem_to_reg : registered controls
//   branch_taken/target : one-cycle redirect and its PC
//   hold                : stall IF/ID/EX
//   mem_error           : sticky memory timeout flag
//   stall_cycles        : hold-cycle performance counter
// ============================================================================
module ex_mem #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_zero,
  input  logic [31:0] ex_read_data2,
  input  logic [4:0]  ex_write_reg,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_address,
  input  logic        ex_branch,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_valid,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [4:0]  write_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        hold,
  output logic        mem_error,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_flush_q, pending_flush_d;

  logic             valid_q, valid_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       wreg_q, wreg_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             branch_taken_q, branch_taken_d;
  logic [31:0]      branch_target_q, branch_target_d;
  logic             mem_error_q, mem_error_d;

  logic             req_w;
  logic             timeout_w;
  logic             hold_w;
  logic             load_w;
  logic             bubble_w;
  logic [31:0]      target_w;

  // In ACCESS the request stays up regardless of the slot contents.
  assign req_w     = (state_q == S_ACCESS) | (valid_q & (mem_read_q | mem_write_q));
  assign timeout_w = (state_q == S_ACCESS) & ~mem_ready & (cnt_q == CNT_W'(MAX_WAIT));
  // The timeout cycle releases the stall so the pipeline advances past the
  // abandoned access.
  assign hold_w    = req_w & ~mem_ready & ~timeout_w;
  assign load_w    = ~hold_w;
  assign bubble_w  = flush | pending_flush_q | ~ex_valid;
  assign target_w  = ex_pc + 32'd4 + (ex_address << 2);

  // --------------------------------------------------------------------------
  // Memory handshake FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_w && !mem_ready) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (mem_ready || timeout_w) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot next-state
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d         = valid_q;
    alu_d           = alu_q;
    wdata_d         = wdata_q;
    wreg_d          = wreg_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    branch_target_d = branch_target_q;
    pending_flush_d = pending_flush_q;
    mem_error_d     = mem_error_q | timeout_w;
    // The redirect is a pulse: it only rises on the edge that loads the branch.
    branch_taken_d  = 1'b0;

    if (load_w) begin
      alu_d           = ex_alu_result;
      wdata_d         = ex_read_data2;
      wreg_d          = ex_write_reg;
      branch_target_d = target_w;
      valid_d         = ~bubble_w;
      mem_read_d      = ~bubble_w & ex_mem_read;
      // A slot flagged as both load and store is treated as a load.
      mem_write_d     = ~bubble_w & ex_mem_write & ~ex_mem_read;
      reg_write_d     = ~bubble_w & ex_reg_write;
      mem_to_reg_d    = ~bubble_w & ex_mem_to_reg;
      branch_taken_d  = ~bubble_w & ex_branch & ex_zero;
      pending_flush_d = 1'b0;
    end else if (flush) begin
      // The occupying instruction is mid-access; the flush is owed to the
      // next instruction that enters the slot.
      pending_flush_d = 1'b1;
    end

    // An abandoned access bubbles the slot on the timeout edge; the sticky
    // mem_error tells the system that the squash happened.
    if (timeout_w) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pending_flush_q <= 1'b0;
      valid_q         <= 1'b0;
      alu_q           <= '0;
      wdata_q         <= '0;
      wreg_q          <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      mem_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_flush_q <= pending_flush_d;
      valid_q         <= valid_d;
      alu_q           <= alu_d;
      wdata_q         <= wdata_d;
      wreg_q          <= wreg_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      mem_error_q     <= mem_error_d;
    end
  end

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (hold_w) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign mem_req       = req_w;
  assign hold          = hold_w;
  assign mem_valid     = valid_q;
  assign alu_result    = alu_q;
  assign write_data    = wdata_q;
  assign write_reg     = wreg_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign reg_write     = reg_write_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign mem_error     = mem_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem
// Purpose  : Self-checking bench for ex_mem: a table of single-cycle vectors
//            followed by hand-written multi-cycle sequences (memory wait,
//            flush under hold, timeout, reset mid-access).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic        ex_zero;
  logic [31:0] ex_read_data2;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_pc;
  logic [31:0] ex_address;
  logic        ex_branch;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  write_reg;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        hold;
  logic        mem_error;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  ex_mem #(.MAX_WAIT(15), .CNT_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_zero       (ex_zero),
    .ex_read_data2 (ex_read_data2),
    .ex_write_reg  (ex_write_reg),
    .ex_pc         (ex_pc),
    .ex_address    (ex_address),
    .ex_branch     (ex_branch),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_valid     (mem_valid),
    .alu_result    (alu_result),
    .write_data    (write_data),
    .write_reg     (write_reg),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hold          (hold),
    .mem_error     (mem_error),
    .stall_cycles  (stall_cycles)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid, flush, zero, branch, mr, mw, rw, m2r;
    logic [31:0] alu, rd2, pc, addr;
    logic [4:0]  wreg;
    logic        e_mv, e_mr, e_mw, e_rw, e_m2r, e_bt, e_req;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(
    input logic valid, input logic fl, input logic zero, input logic br,
    input logic mr, input logic mw, input logic rw, input logic m2r,
    input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wreg,
    input logic [31:0] pc, input logic [31:0] addr,
    input logic e_mv, input logic e_mr, input logic e_mw, input logic e_rw,
    input logic e_m2r, input logic e_bt, input logic e_req, input logic [31:0] e_target);
    vec_t v;
    v.valid = valid; v.flush = fl; v.zero = zero; v.branch = br;
    v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r;
    v.alu = alu; v.rd2 = rd2; v.wreg = wreg; v.pc = pc; v.addr = addr;
    v.e_mv = e_mv; v.e_mr = e_mr; v.e_mw = e_mw; v.e_rw = e_rw;
    v.e_m2r = e_m2r; v.e_bt = e_bt; v.e_req = e_req; v.e_target = e_target;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    flush = 0; ex_valid = 0; ex_alu_result = 0; ex_zero = 0; ex_read_data2 = 0;
    ex_write_reg = 0; ex_pc = 0; ex_address = 0; ex_branch = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
  endtask

  task automatic drive_op(input logic mr, input logic mw, input logic rw,
                          input logic [31:0] alu, input logic [31:0] rd2);
    drive_idle();
    ex_valid = 1; ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw;
    ex_alu_result = alu; ex_read_data2 = rd2; ex_write_reg = 5'd3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},       {31'd0, mem_req},      32'd0);
    chk({tag, ".hold"},          {31'd0, hold},         32'd0);
    chk({tag, ".mem_valid"},     {31'd0, mem_valid},    32'd0);
    chk({tag, ".mem_error"},     {31'd0, mem_error},    32'd0);
    chk({tag, ".ctrl"},          {28'd0, mem_read, mem_write, reg_write, mem_to_reg}, 32'd0);
    chk({tag, ".branch_taken"},  {31'd0, branch_taken}, 32'd0);
    chk({tag, ".alu_result"},    alu_result,            32'd0);
    chk({tag, ".write_data"},    write_data,            32'd0);
    chk({tag, ".write_reg"},     {27'd0, write_reg},    32'd0);
    chk({tag, ".branch_target"}, branch_target,         32'd0);
    chk({tag, ".stall_cycles"},  stall_cycles,          32'd0);
  endtask

  int hold_cnt;
  int hold_exp;
  bit done;

  initial begin
    drive_idle();
    mem_ready = 1'b1;

    //            vl fl z  br mr mw rw m2r alu           rd2           wreg   pc            addr          mv mr mw rw m2 bt rq target
    vecs[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 32'h10,       32'h0,        5'd5,  32'h0,        32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h4);
    vecs[1] = mk(1, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  32'h100,      32'hFFFFFFFE, 1, 0, 0, 0, 0, 1, 0, 32'hFC);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h33,       32'h44,       5'd7,  32'h200,      32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h204);
    vecs[3] = mk(1, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  32'h40,       32'h3,        1, 0, 0, 0, 0, 0, 0, 32'h50);
    vecs[4] = mk(1, 1, 1, 1, 0, 0, 1, 0, 32'h5,        32'h0,        5'd3,  32'h80,       32'h1,        0, 0, 0, 0, 0, 0, 0, 32'h88);
    vecs[5] = mk(1, 0, 0, 0, 1, 0, 1, 1, 32'h1000,     32'h0,        5'd9,  32'h10,       32'h0,        1, 1, 0, 1, 1, 0, 1, 32'h14);
    vecs[6] = mk(1, 0, 0, 0, 0, 1, 0, 0, 32'h2000,     32'hDEADBEEF, 5'd0,  32'h14,       32'h0,        1, 0, 1, 0, 0, 0, 1, 32'h18);
    vecs[7] = mk(1, 0, 0, 0, 1, 1, 1, 1, 32'h3000,     32'h12,       5'd4,  32'h18,       32'h0,        1, 1, 0, 1, 1, 0, 1, 32'h1C);
    vecs[8] = mk(0, 0, 1, 1, 1, 1, 1, 1, 32'h44,       32'h55,       5'd31, 32'h1C,       32'h10,       0, 0, 0, 0, 0, 0, 0, 32'h60);
    vecs[9] = mk(1, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  32'hFFFFFFF0, 32'h10,       1, 0, 0, 0, 0, 1, 0, 32'h34);

    // ---------------- reset state ----------------
    reset = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // ---------------- single-cycle vectors, zero-wait memory ----------------
    for (int i = 0; i < 10; i++) begin
      flush = vecs[i].flush; ex_valid = vecs[i].valid; ex_zero = vecs[i].zero;
      ex_branch = vecs[i].branch; ex_mem_read = vecs[i].mr; ex_mem_write = vecs[i].mw;
      ex_reg_write = vecs[i].rw; ex_mem_to_reg = vecs[i].m2r;
      ex_alu_result = vecs[i].alu; ex_read_data2 = vecs[i].rd2; ex_write_reg = vecs[i].wreg;
      ex_pc = vecs[i].pc; ex_address = vecs[i].addr;
      step();
      chk($sformatf("v%0d.mem_valid", i),     {31'd0, mem_valid},    {31'd0, vecs[i].e_mv});
      chk($sformatf("v%0d.mem_read", i),      {31'd0, mem_read},     {31'd0, vecs[i].e_mr});
      chk($sformatf("v%0d.mem_write", i),     {31'd0, mem_write},    {31'd0, vecs[i].e_mw});
      chk($sformatf("v%0d.reg_write", i),     {31'd0, reg_write},    {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d.mem_to_reg", i),    {31'd0, mem_to_reg},   {31'd0, vecs[i].e_m2r});
      chk($sformatf("v%0d.branch_taken", i),  {31'd0, branch_taken}, {31'd0, vecs[i].e_bt});
      chk($sformatf("v%0d.branch_target", i), branch_target,         vecs[i].e_target);
      chk($sformatf("v%0d.mem_req", i),       {31'd0, mem_req},      {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d.hold", i),          {31'd0, hold},         32'd0);
      chk($sformatf("v%0d.alu_result", i),    alu_result,            vecs[i].alu);
      chk($sformatf("v%0d.write_data", i),    write_data,            vecs[i].rd2);
      chk($sformatf("v%0d.write_reg", i),     {27'd0, write_reg},    {27'd0, vecs[i].wreg});
    end

    // ---------------- load with 3-cycle memory delay ----------------
    reset = 1'b1; drive_idle(); step(); reset = 1'b0;
    mem_ready = 1'b0;
    drive_op(1, 0, 1, 32'hA0, 32'h0);
    step();
    drive_op(0, 0, 1, 32'hB0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wait%0d.hold", c),       {31'd0, hold},    32'd1);
      chk($sformatf("wait%0d.alu_frozen", c), alu_result,       32'hA0);
      chk($sformatf("wait%0d.mem_read", c),   {31'd0, mem_read}, 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait.ready_hold", {31'd0, hold},    32'd0);
    chk("wait.ready_req",  {31'd0, mem_req}, 32'd1);
    step();
    chk("wait.next_alu",   alu_result,         32'hB0);
    chk("wait.next_mr",    {31'd0, mem_read},  32'd0);
    chk("wait.next_req",   {31'd0, mem_req},   32'd0);
`ifdef EX_MEM_PERF_EN
    chk("wait.stall_cycles", stall_cycles, 32'd3);
`else
    chk("wait.stall_cycles", stall_cycles, 32'd0);
`endif

    // ---------------- flush while a store waits ----------------
    reset = 1'b1; drive_idle(); step(); reset = 1'b0;
    mem_ready = 1'b0;
    drive_op(0, 1, 0, 32'h2000, 32'h55);
    step();
    chk("fl.store_hold", {31'd0, hold}, 32'd1);
    drive_op(0, 0, 1, 32'h77, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl.store_still_valid", {31'd0, mem_valid}, 32'd1);
    chk("fl.store_mem_write",   {31'd0, mem_write}, 32'd1);
    chk("fl.store_data",        write_data,         32'h55);
    mem_ready = 1'b1;
    #1;
    chk("fl.complete_hold", {31'd0, hold}, 32'd0);
    step();
    chk("fl.bubble_valid", {31'd0, mem_valid}, 32'd0);
    chk("fl.bubble_rw",    {31'd0, reg_write}, 32'd0);
    chk("fl.bubble_alu",   alu_result,         32'h77);
    step();
    chk("fl.cleared_valid", {31'd0, mem_valid}, 32'd1);
    chk("fl.cleared_rw",    {31'd0, reg_write}, 32'd1);

    // ---------------- timeout ----------------
    reset = 1'b1; drive_idle(); step(); reset = 1'b0;
    mem_ready = 1'b0;
    drive_op(1, 0, 1, 32'hC0, 32'h0);
    step();
    drive_op(0, 0, 1, 32'h99, 32'h0);
    hold_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (hold) begin
        hold_cnt++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    chk("to.bound_reached", {31'd0, done}, 32'd1);
    hold_exp = 15;
    chk("to.hold_cycles", hold_cnt, hold_exp);
    chk("to.req_in_timeout_cycle", {31'd0, mem_req},   32'd1);
    chk("to.no_error_yet",         {31'd0, mem_error}, 32'd0);
    step();
    chk("to.mem_error",  {31'd0, mem_error}, 32'd1);
    chk("to.bubble_mv",  {31'd0, mem_valid}, 32'd0);
    chk("to.bubble_rw",  {31'd0, reg_write}, 32'd0);
    chk("to.bubble_mr",  {31'd0, mem_read},  32'd0);
    chk("to.req_idle",   {31'd0, mem_req},   32'd0);
    chk("to.hold_idle",  {31'd0, hold},      32'd0);
    chk("to.alu",        alu_result,         32'h99);
    step();
    chk("to.resume_mv",  {31'd0, mem_valid}, 32'd1);
    chk("to.sticky_err", {31'd0, mem_error}, 32'd1);

    // ---------------- reset mid-access ----------------
    drive_op(1, 0, 1, 32'hD0, 32'h0);
    step();
    drive_idle();
    step();
    step();
    chk("rst.in_access_hold", {31'd0, hold},      32'd1);
    chk("rst.error_before",   {31'd0, mem_error}, 32'd1);
    reset = 1'b1;
    step();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    step();
    chk("rst.after_req", {31'd0, mem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- EX/MEM pipeline stage, directly downstream of the ID/EX register.
- Captures execute-stage results, resolves branches (taken flag plus registered target) and owns the data-memory request handshake.
- Back-pressures the upstream pipeline with `hold` while a load/store waits on memory.
- Converts flushes and memory timeouts into bubbles.

Parameters:
- `MAX_WAIT`, default 15: number of `mem_ready`-low cycles tolerated in ACCESS before the access is abandoned.
- `CNT_W`, default 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- `clock` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: replace the incoming instruction with a bubble.
- `ex_valid` in 1: incoming slot holds a real instruction.
- `ex_alu_result` in 32: ALU output; also the memory address.
- `ex_zero` in 1: ALU zero flag.
- `ex_read_data2` in 32: store data.
- `ex_write_reg` in 5: destination register (rd or rt already selected).
- `ex_pc` in 32: PC of the instruction.
- `ex_address` in 32: sign-extended immediate.
- `ex_branch`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg` in 1 each: control bits.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_req` out 1: memory access request.
- `mem_valid` out 1: slot valid.
- `alu_result` out 32, `write_data` out 32, `write_reg` out 5: registered datapath.
- `mem_read`, `mem_write`, `reg_write`, `mem_to_reg` out 1 each: registered controls.
- `branch_taken` out 1: one-cycle redirect.
- `branch_target` out 32: redirect PC.
- `hold` out 1: stall IF/ID/EX.
- `mem_error` out 1: sticky timeout flag.
- `stall_cycles` out 32: performance counter.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; wait counter 0; `pending_flush` 0.
  - Reset overrides every other input, including mid-access; `mem_req` drops on the next edge.
- Load condition: `load = ~hold`. On every load edge the slot captures all `ex_*` fields.
- Bubble on load when `flush`, `pending_flush` or `~ex_valid`:
  - Cleared: `mem_valid`, `mem_read`, `mem_write`, `reg_write`, `mem_to_reg`, `branch_taken`.
  - Datapath fields still captured.
  - `pending_flush` cleared.
- Flush while `hold=1`: sets `pending_flush`. It applies to the next loaded instruction, never to the instruction occupying the slot.
- Branch:
  - On load, `branch_taken <= ex_valid & ex_branch & ex_zero & ~flush & ~pending_flush`.
  - On load, `branch_target <= ex_pc + 4 + (ex_address << 2)`, mod 2^32, wrap-around ignored.
  - `branch_taken` is high exactly one cycle per branch.
- Memory FSM, two states:
  - IDLE: `mem_req = mem_valid & (mem_read | mem_write)`.
    - `mem_req & mem_ready`: access completes; stay IDLE, slot may load.
    - `mem_req & ~mem_ready`: go to ACCESS, wait counter = 1.
  - ACCESS: `mem_req = 1`.
    - `mem_ready`: completion; go to IDLE; counter cleared.
    - Else, counter == MAX_WAIT: set `mem_error` (sticky until reset), clear `mem_valid`/`reg_write`/`mem_read`/`mem_write` (bubble), go to IDLE.
    - Else: counter increments.
- `hold = mem_req & ~mem_ready & ~timeout_this_cycle`, combinational.
  - Zero-wait memory (`mem_ready` high in the request cycle) therefore gives no stall.
  - While `hold`, all slot registers keep their values.
- Load and store are mutually exclusive. If both are asserted the load wins: `mem_write` is registered as 0.
- Latency: 1 cycle, `ex_*` to outputs, when not holding.

Optional Feature:
- Macro `EX_MEM_PERF_EN`.
- When defined: `stall_cycles` increments on every cycle with `hold=1`, wraps at 2^32 and resets to 0.
- When undefined: `stall_cycles` is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- ALU op, no memory: `ex_valid=1`, `ex_alu_result=0x10`, `ex_reg_write=1`. One edge later `alu_result=0x10`, `reg_write=1`, `mem_req=0`, `hold=0`.
- Taken branch: `ex_pc=0x100`, `ex_address=0xFFFFFFFE`, `ex_zero=1`, `ex_branch=1`. Next cycle `branch_taken=1`, `branch_target=0x0FC`; the following cycle `branch_taken=0`.
- Load with 3-cycle `mem_ready` delay: `hold=1` for 3 cycles, outputs frozen, next instruction captured on the edge after `mem_ready`; `stall_cycles=3` with `EX_MEM_PERF_EN`.
- Flush during hold: flush pulse while a store waits. Store completes normally; the next loaded instruction becomes a bubble (`mem_valid=0`); `pending_flush` then clears.
- Timeout: `MAX_WAIT=15`, `mem_ready` held 0. After 15 ACCESS cycles `mem_error=1`, slot bubbled, `hold` drops, FSM returns to IDLE.
- Reset mid-access: assert `reset` in ACCESS. Next cycle `mem_req=0`, `hold=0`, `mem_error=0`, all outputs 0.
